coherent_dcache: RTL and testbench

- Per-core L1 data cache sitting directly upstream of the bus/coherence controller.
- One instance per CPU. Serves datapath loads/stores and issues two-word block fills and writebacks on the controller's d-side.
- Answers controller snoops under an MSI protocol. On halt, flushes dirty lines before asserting flushed.
- Direct-mapped: 16 sets, 2-word blocks.

---
 rtl/coherent_dcache.sv | 202 ++++++++++++++++++++
 tb/tb_coherent_dcache.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/coherent_dcache.sv
// Direct-mapped, write-back L1 data cache with two-word blocks and MSI snooping.
// Fills and writebacks go through the controller d-side; halt flushes dirty lines, then parks in DONE.
module coherent_dcache #(
  parameter int SETS  = 16,
  parameter int CPUID = 0
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        halt,
  input  logic        dmemREN,
  input  logic        dmemWEN,
  input  logic [31:0] dmemaddr,
  input  logic [31:0] dmemstore,
  output logic [31:0] dmemload,
  output logic        dhit,
  output logic        flushed,
  output logic        dREN,
  output logic        dWEN,
  output logic [31:0] daddr,
  output logic [31:0] dstore,
  input  logic [31:0] dload,
  input  logic        dwait,
  output logic        cctrans,
  output logic        ccwrite,
  input  logic        ccwait,
  input  logic        ccinv,
  input  logic [31:0] ccsnoopaddr
);
  localparam int IW = $clog2(SETS);
  localparam int TW = 29 - IW;

  typedef enum logic [3:0] {
    IDLE, WB1, WB2, ALLOC1, ALLOC2, UPGR, SNP_WB1, SNP_WB2,
    FLUSH_CHK, FLUSH_WB1, FLUSH_WB2, DONE
  } state_t;

  typedef enum logic [1:0] {LINE_I, LINE_S, LINE_M} line_t;

  state_t          state, next_state;
  line_t           lstate [SETS];
  logic [TW-1:0]   tags   [SETS];
  logic [31:0]     data_q [SETS][2];
  logic [IW-1:0]   flush_idx;
  logic [TW-1:0]   snp_tag;
  logic [IW-1:0]   snp_idx;
  logic            snp_inv;

  logic [IW-1:0]   req_idx, snp_idx_in;
  logic [TW-1:0]   req_tag, snp_tag_in;
  logic            req_word, req_match, snp_hit, flush_last;
  logic            unused_bits;

  assign req_idx    = dmemaddr[3 +: IW];
  assign req_tag    = dmemaddr[31 -: TW];
  assign req_word   = dmemaddr[2];
  assign req_match  = (tags[req_idx] == req_tag);
  assign snp_idx_in = ccsnoopaddr[3 +: IW];
  assign snp_tag_in = ccsnoopaddr[31 -: TW];
  assign snp_hit    = (lstate[snp_idx_in] != LINE_I) && (tags[snp_idx_in] == snp_tag_in);
  assign flush_last = (flush_idx == IW'(SETS - 1));
  assign dmemload   = data_q[req_idx][req_word];
  assign unused_bits = ^{dmemaddr[1:0], ccsnoopaddr[2:0]};

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= IDLE;
    else       state <= next_state;
  end

  // Next state and bus/datapath outputs; snoops outrank halt, halt outranks datapath service.
  always_comb begin
    next_state = state;
    dhit    = 1'b0;
    flushed = 1'b0;
    dREN    = 1'b0;
    dWEN    = 1'b0;
    daddr   = '0;
    dstore  = '0;
    cctrans = 1'b0;
    ccwrite = 1'b0;
    case (state)
      IDLE: begin
        if (ccwait) begin
          if (snp_hit && lstate[snp_idx_in] == LINE_M) begin
            cctrans    = 1'b1;
            next_state = SNP_WB1;
          end
        end else if (halt) begin
          next_state = FLUSH_CHK;
        end else if (dmemWEN) begin
          if (req_match && lstate[req_idx] == LINE_M)      dhit = 1'b1;
          else if (req_match && lstate[req_idx] == LINE_S) next_state = UPGR;
          else if (lstate[req_idx] == LINE_M)              next_state = WB1;
          else                                             next_state = ALLOC1;
        end else if (dmemREN) begin
          if (req_match && lstate[req_idx] != LINE_I)      dhit = 1'b1;
          else if (lstate[req_idx] == LINE_M)              next_state = WB1;
          else                                             next_state = ALLOC1;
        end
      end
      WB1, WB2: begin
        dWEN   = 1'b1;
        daddr  = {tags[req_idx], req_idx, (state == WB2), 2'b00};
        dstore = data_q[req_idx][state == WB2];
        if (!dwait) next_state = (state == WB1) ? WB2 : ALLOC1;
      end
      ALLOC1, ALLOC2: begin
        dREN    = 1'b1;
        cctrans = 1'b1;
        ccwrite = dmemWEN;
        daddr   = {req_tag, req_idx, (state == ALLOC2), 2'b00};
        if (!dwait) next_state = (state == ALLOC1) ? ALLOC2 : IDLE;
      end
      UPGR: begin
        cctrans    = 1'b1;
        ccwrite    = 1'b1;
        daddr      = dmemaddr;
        next_state = IDLE;
      end
      SNP_WB1, SNP_WB2: begin
        daddr  = {snp_tag, snp_idx, (state == SNP_WB2), 2'b00};
        dstore = data_q[snp_idx][state == SNP_WB2];
        if (!dwait) next_state = (state == SNP_WB1) ? SNP_WB2 : IDLE;
      end
      FLUSH_CHK: begin
        if (lstate[flush_idx] == LINE_M) next_state = FLUSH_WB1;
        else if (flush_last)             next_state = DONE;
      end
      FLUSH_WB1, FLUSH_WB2: begin
        dWEN   = 1'b1;
        daddr  = {tags[flush_idx], flush_idx, (state == FLUSH_WB2), 2'b00};
        dstore = data_q[flush_idx][state == FLUSH_WB2];
        if (!dwait) begin
          if (state == FLUSH_WB1) next_state = FLUSH_WB2;
          else                    next_state = flush_last ? DONE : FLUSH_CHK;
        end
      end
      DONE: flushed = 1'b1;
      default: next_state = IDLE;
    endcase
  end

  // Line array, snoop bookkeeping and flush cursor; reset invalidates every line at once.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      flush_idx <= '0;
      snp_tag   <= '0;
      snp_idx   <= '0;
      snp_inv   <= 1'b0;
      for (int i = 0; i < SETS; i++) begin
        lstate[i]    <= LINE_I;
        tags[i]      <= '0;
        data_q[i][0] <= '0;
        data_q[i][1] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (ccwait) begin
            if (snp_hit && lstate[snp_idx_in] == LINE_M) begin
              snp_tag <= snp_tag_in;
              snp_idx <= snp_idx_in;
              snp_inv <= ccinv;
            end else if (snp_hit && ccinv) begin
              lstate[snp_idx_in] <= LINE_I;
            end
          end else if (halt) begin
            flush_idx <= '0;
          end else if (dhit && dmemWEN) begin
            data_q[req_idx][req_word] <= dmemstore;
          end
        end
        UPGR: lstate[req_idx] <= LINE_M;
        ALLOC1: if (!dwait) data_q[req_idx][0] <= dload;
        ALLOC2: begin
          if (!dwait) begin
            data_q[req_idx][1] <= dload;
            tags[req_idx]      <= req_tag;
            lstate[req_idx]    <= dmemWEN ? LINE_M : LINE_S;
          end
        end
        SNP_WB1: snp_inv <= snp_inv | ccinv;
        SNP_WB2: begin
          if (!dwait) lstate[snp_idx] <= (snp_inv | ccinv) ? LINE_I : LINE_S;
          else        snp_inv <= snp_inv | ccinv;
        end
        FLUSH_CHK: begin
          if (lstate[flush_idx] != LINE_M) begin
            lstate[flush_idx] <= LINE_I;
            if (!flush_last) flush_idx <= flush_idx + IW'(1);
          end
        end
        FLUSH_WB2: begin
          if (!dwait) begin
            lstate[flush_idx] <= LINE_I;
            if (!flush_last) flush_idx <= flush_idx + IW'(1);
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_coherent_dcache.sv
// Self-checking bench for coherent_dcache: vector table for accesses, bus scoreboard,
// and hand-written sequences for upgrade, snoop, ccwait blocking, flush and async reset.
module tb_coherent_dcache;
  logic        CLK, nRST, halt, dmemREN, dmemWEN;
  logic [31:0] dmemaddr, dmemstore, dmemload, daddr, dstore, dload, ccsnoopaddr;
  logic        dhit, flushed, dREN, dWEN, dwait, cctrans, ccwrite, ccwait, ccinv;

  coherent_dcache #(.SETS(16), .CPUID(0)) dut (
    .CLK(CLK), .nRST(nRST), .halt(halt), .dmemREN(dmemREN), .dmemWEN(dmemWEN),
    .dmemaddr(dmemaddr), .dmemstore(dmemstore), .dmemload(dmemload), .dhit(dhit),
    .flushed(flushed), .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dload(dload), .dwait(dwait), .cctrans(cctrans), .ccwrite(ccwrite),
    .ccwait(ccwait), .ccinv(ccinv), .ccsnoopaddr(ccsnoopaddr)
  );

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    bit          ccw;
  } busOp_t;

  typedef struct {
    bit          wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] expLoad;
    bit          hasWb;
    logic [31:0] wbBase;
    logic [31:0] wbD0;
    logic [31:0] wbD1;
    bit          hasFill;
  } vec_t;

  busOp_t      sb[$];
  vec_t        vecs[11];
  logic [31:0] mem [logic [31:0]];
  int          passCount = 0;
  int          checkCount = 0;
  bit          busAuto = 1'b1;
  bit          manualDwait = 1'b1;
  int          busCnt = 0;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  function automatic logic [31:0] pat(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [31:0] memRead(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return pat(a);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  task automatic pushOp(input bit wr, input logic [31:0] addr, input logic [31:0] data, input bit ccw);
    busOp_t op;
    op.wr = wr; op.addr = addr; op.data = data; op.ccw = ccw;
    sb.push_back(op);
  endtask

  // Memory side of the controller: each word takes three cycles, dwait low on the last.
  task automatic busResponder();
    busOp_t e;
    forever begin
      @(negedge CLK);
      if (!busAuto) begin
        dwait  = manualDwait;
        busCnt = 0;
      end else if (dREN || dWEN) begin
        if (busCnt == 2) begin
          busCnt = 0;
          dwait  = 1'b0;
          checkOutput("bus_pending", 32'(sb.size() > 0), 32'd1);
          if (sb.size() > 0) begin
            e = sb.pop_front();
            checkOutput("bus_kind", {31'd0, dWEN}, {31'd0, e.wr});
            checkOutput("bus_addr", daddr, e.addr);
            if (e.wr) begin
              checkOutput("bus_data", dstore, e.data);
              mem[daddr] = dstore;
            end else begin
              checkOutput("bus_cc", {30'd0, cctrans, ccwrite}, {30'd0, 1'b1, e.ccw});
            end
          end
          dload = memRead(daddr);
        end else begin
          busCnt++;
          dwait = 1'b1;
        end
      end else begin
        busCnt = 0;
        dwait  = 1'b1;
      end
    end
  endtask

  task automatic setVec(input int i, input bit wen, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] expLoad, input bit hasWb, input logic [31:0] wbBase,
                        input logic [31:0] wbD0, input logic [31:0] wbD1, input bit hasFill);
    vecs[i].wen = wen; vecs[i].addr = addr; vecs[i].wdata = wdata; vecs[i].expLoad = expLoad;
    vecs[i].hasWb = hasWb; vecs[i].wbBase = wbBase; vecs[i].wbD0 = wbD0; vecs[i].wbD1 = wbD1;
    vecs[i].hasFill = hasFill;
  endtask

  task automatic applyStimulus(input int i);
    vec_t        v;
    logic [31:0] fb, load;
    bit          got;
    v = vecs[i];
    fb = {v.addr[31:3], 3'b000};
    if (v.hasWb) begin
      pushOp(1'b1, v.wbBase, v.wbD0, 1'b0);
      pushOp(1'b1, v.wbBase + 32'd4, v.wbD1, 1'b0);
    end
    if (v.hasFill) begin
      pushOp(1'b0, fb, 32'd0, v.wen);
      pushOp(1'b0, fb + 32'd4, 32'd0, v.wen);
    end
    dmemWEN = v.wen; dmemREN = !v.wen; dmemaddr = v.addr; dmemstore = v.wdata;
    got = 1'b0; load = '0;
    for (int c = 0; c < 200; c++) begin
      @(negedge CLK);
      if (dhit) begin
        got  = 1'b1;
        load = dmemload;
        break;
      end
    end
    @(posedge CLK); #1;
    dmemREN = 1'b0; dmemWEN = 1'b0;
    checkOutput($sformatf("v%0d_hit", i), {31'd0, got}, 32'd1);
    if (!v.wen) checkOutput($sformatf("v%0d_load", i), load, v.expLoad);
    checkOutput($sformatf("v%0d_drained", i), 32'(sb.size()), 32'd0);
  endtask

  // Store to an S line: one UPGR cycle claiming ownership, then the write hits.
  task automatic doUpgrade(input logic [31:0] addr, input logic [31:0] wdata);
    dmemWEN = 1'b1; dmemaddr = addr; dmemstore = wdata;
    @(negedge CLK);
    checkOutput("upgr_first_nohit", {31'd0, dhit}, 32'd0);
    @(negedge CLK);
    checkOutput("upgr_cc", {29'd0, cctrans, ccwrite, dhit}, 32'b110);
    checkOutput("upgr_addr", daddr, addr);
    @(negedge CLK);
    checkOutput("upgr_then_hit", {31'd0, dhit}, 32'd1);
    @(posedge CLK); #1;
    dmemWEN = 1'b0;
  endtask

  initial begin
    bit got;
    int blocked;
    nRST = 1'b0; halt = 1'b0; dmemREN = 1'b0; dmemWEN = 1'b0; dmemaddr = '0; dmemstore = '0;
    ccwait = 1'b0; ccinv = 1'b0; ccsnoopaddr = '0; dwait = 1'b1; dload = '0;
    fork busResponder(); join_none

    setVec(0,  1'b0, 32'h40,  32'h0,         pat(32'h40),  1'b0, 32'h0,  32'h0,         32'h0,       1'b1);
    setVec(1,  1'b0, 32'h44,  32'h0,         pat(32'h44),  1'b0, 32'h0,  32'h0,         32'h0,       1'b0);
    setVec(2,  1'b0, 32'h40,  32'h0,         32'hDEADBEEF, 1'b0, 32'h0,  32'h0,         32'h0,       1'b0);
    setVec(3,  1'b0, 32'h240, 32'h0,         pat(32'h240), 1'b1, 32'h40, 32'hDEADBEEF,  pat(32'h44), 1'b1);
    setVec(4,  1'b1, 32'h84,  32'h11110084,  32'h0,        1'b0, 32'h0,  32'h0,         32'h0,       1'b1);
    setVec(5,  1'b0, 32'h84,  32'h0,         32'h11110084, 1'b0, 32'h0,  32'h0,         32'h0,       1'b0);
    setVec(6,  1'b0, 32'h40,  32'h0,         32'hDEADBEEF, 1'b0, 32'h0,  32'h0,         32'h0,       1'b1);
    setVec(7,  1'b0, 32'h44,  32'h0,         pat(32'h44),  1'b0, 32'h0,  32'h0,         32'h0,       1'b1);
    setVec(8,  1'b1, 32'h10,  32'hAAAA0010,  32'h0,        1'b0, 32'h0,  32'h0,         32'h0,       1'b1);
    setVec(9,  1'b1, 32'h38,  32'hBBBB0038,  32'h0,        1'b0, 32'h0,  32'h0,         32'h0,       1'b1);
    setVec(10, 1'b0, 32'h60,  32'h0,         pat(32'h60),  1'b0, 32'h0,  32'h0,         32'h0,       1'b1);

    repeat (3) @(negedge CLK);
    checkOutput("reset_outputs", {26'd0, dhit, flushed, dREN, dWEN, cctrans, ccwrite}, 32'd0);
    checkOutput("reset_daddr", daddr, 32'd0);
    checkOutput("reset_dmemload", dmemload, 32'd0);
    @(posedge CLK); #1;
    nRST = 1'b1;
    @(posedge CLK); #1;

    for (int i = 0; i <= 1; i++) applyStimulus(i);
    doUpgrade(32'h40, 32'hDEADBEEF);
    for (int i = 2; i <= 6; i++) applyStimulus(i);

    // Dirty the line again, then a snooping invalidate must supply both words and drop it to I.
    doUpgrade(32'h40, 32'h22220000);
    busAuto = 1'b0; manualDwait = 1'b0;
    @(posedge CLK); #1;
    ccwait = 1'b1; ccsnoopaddr = 32'h40; ccinv = 1'b1;
    @(negedge CLK);
    checkOutput("snoop_cctrans", {30'd0, cctrans, dhit}, 32'b10);
    @(negedge CLK);
    checkOutput("snoop_wb1_addr", daddr, 32'h40);
    checkOutput("snoop_wb1_data", dstore, 32'h22220000);
    checkOutput("snoop_wb1_nodwen", {31'd0, dWEN}, 32'd0);
    @(negedge CLK);
    checkOutput("snoop_wb2_addr", daddr, 32'h44);
    checkOutput("snoop_wb2_data", dstore, pat(32'h44));
    @(posedge CLK); #1;
    ccwait = 1'b0; ccinv = 1'b0; busAuto = 1'b1; manualDwait = 1'b1;
    applyStimulus(7);

    // A pending hit is held off while the controller snoops (snoop misses here).
    ccwait = 1'b1; ccsnoopaddr = 32'h1000; dmemREN = 1'b1; dmemaddr = 32'h40;
    blocked = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      if (!dhit && !cctrans) blocked++;
    end
    checkOutput("ccwait_blocks", 32'(blocked), 32'd3);
    @(posedge CLK); #1;
    ccwait = 1'b0;
    @(negedge CLK);
    checkOutput("ccwait_release_hit", {31'd0, dhit}, 32'd1);
    checkOutput("ccwait_release_load", dmemload, 32'hDEADBEEF);
    @(posedge CLK); #1;
    dmemREN = 1'b0;

    for (int i = 8; i <= 10; i++) applyStimulus(i);

    // M lines at index 0, 2, 7 must be written back in order; S lines at 8 and 12 silently dropped.
    pushOp(1'b1, 32'h80, pat(32'h80), 1'b0);
    pushOp(1'b1, 32'h84, 32'h11110084, 1'b0);
    pushOp(1'b1, 32'h10, 32'hAAAA0010, 1'b0);
    pushOp(1'b1, 32'h14, pat(32'h14), 1'b0);
    pushOp(1'b1, 32'h38, 32'hBBBB0038, 1'b0);
    pushOp(1'b1, 32'h3C, pat(32'h3C), 1'b0);
    halt = 1'b1;
    got = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      @(negedge CLK);
      if (flushed) begin
        got = 1'b1;
        break;
      end
    end
    checkOutput("flush_done", {31'd0, got}, 32'd1);
    checkOutput("flush_drained", 32'(sb.size()), 32'd0);
    ccwait = 1'b1; ccsnoopaddr = 32'h80;
    for (int c = 0; c < 4; c++) begin
      @(negedge CLK);
      checkOutput("done_hold", {27'd0, flushed, dWEN, dREN, cctrans, dhit}, 32'b10000);
      checkOutput("done_daddr", daddr, 32'd0);
    end
    @(posedge CLK); #1;
    nRST = 1'b0;
    #1;
    checkOutput("reset_clears_flushed", {31'd0, flushed}, 32'd0);
    halt = 1'b0; ccwait = 1'b0;
    @(posedge CLK); #1;
    nRST = 1'b1;

    // Reset in the middle of a fill must drop dREN without waiting for a clock edge.
    busAuto = 1'b0; manualDwait = 1'b1;
    @(posedge CLK); #1;
    dmemREN = 1'b1; dmemaddr = 32'h200;
    @(negedge CLK);
    @(negedge CLK);
    checkOutput("midfill_dren", {31'd0, dREN}, 32'd1);
    checkOutput("midfill_daddr", daddr, 32'h200);
    #2;
    nRST = 1'b0;
    #1;
    checkOutput("async_abort", {29'd0, dREN, dWEN, cctrans}, 32'd0);
    dmemREN = 1'b0;
    @(posedge CLK); #1;
    nRST = 1'b1;
    @(posedge CLK); #1;
    checkOutput("final_drained", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end
endmodule
